adxl362_spi_responder: RTL and testbench

ADXL362_SPI_RESPONDER -- requirements
Module: adxl362_spi_responder

---
 rtl/adxl362_spi_responder_pkg.sv | 34 +++
 rtl/adxl362_spi_responder_spi_input_sync.sv | 53 +++++
 rtl/adxl362_spi_responder.sv | 141 ++++++++++++++
 tb/tb_adxl362_spi_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adxl362_spi_responder_pkg.sv
// adxl362_spi_responder_pkg: register map, opcodes, ID constants and FSM states shared by the responder.
package adxl362_spi_responder_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, SKIP} state_t;
    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
    localparam logic [7:0] DEVID_AD_VAL   = 8'hAD;
    localparam logic [7:0] DEVID_MST_VAL  = 8'h1D;
    localparam logic [7:0] REVID_VAL      = 8'h01;
    localparam logic [7:0] STATUS_VAL     = 8'h41;
    localparam logic [7:0] A_DEVID_AD     = 8'h00;
    localparam logic [7:0] A_DEVID_MST    = 8'h01;
    localparam logic [7:0] A_PARTID       = 8'h02;
    localparam logic [7:0] A_REVID        = 8'h03;
    localparam logic [7:0] A_XDATA        = 8'h08;
    localparam logic [7:0] A_YDATA        = 8'h09;
    localparam logic [7:0] A_ZDATA        = 8'h0A;
    localparam logic [7:0] A_STATUS       = 8'h0B;
    localparam logic [7:0] A_XDATA_L      = 8'h0E;
    localparam logic [7:0] A_XDATA_H      = 8'h0F;
    localparam logic [7:0] A_YDATA_L      = 8'h10;
    localparam logic [7:0] A_YDATA_H      = 8'h11;
    localparam logic [7:0] A_ZDATA_L      = 8'h12;
    localparam logic [7:0] A_ZDATA_H      = 8'h13;
    localparam logic [7:0] A_SOFT_RESET   = 8'h1F;
    localparam logic [7:0] A_FILE_FIRST   = 8'h20;
    localparam logic [7:0] A_FILE_LAST    = 8'h2E;
    localparam logic [7:0] A_POWER_CTL    = 8'h2D;

    // Upper byte of a 12-bit sample: sign bit replicated above bits [11:8].
    function automatic logic [7:0] high_byte(input logic [11:0] s);
        return {{4{s[11]}}, s[11:8]};
    endfunction
endpackage

// File: rtl/adxl362_spi_responder_spi_input_sync.sv
// spi_input_sync: synchronizes SCLK/CSN/MOSI into the clk domain and flags their edges.
// Ports: clk, rst_n (sync, active-low); sclk/csn/mosi raw pins;
//        sclk_rise/sclk_fall/csn_fall/csn_rise one-cycle edge strobes; mosi_bit synchronized MOSI.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic csn,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csn_fall,
    output logic csn_rise,
    output logic mosi_bit
);
    logic [SYNC_STAGES-1:0] sclk_sh, csn_sh, mosi_sh, fill;
    logic sclk_d, csn_d, armed;
    logic sclk_s, csn_s;

    assign sclk_s   = sclk_sh[SYNC_STAGES-1];
    assign csn_s    = csn_sh[SYNC_STAGES-1];
    assign mosi_bit = mosi_sh[SYNC_STAGES-1];

    // armed blocks a CSN fall until CSN has been seen high with the
    // pipeline refilled from the pin, so a reset taken mid-transaction
    // waits for a fresh select instead of decoding a partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sh <= '0;
            csn_sh  <= '1;
            mosi_sh <= '0;
            fill    <= '0;
            sclk_d  <= 1'b0;
            csn_d   <= 1'b1;
            armed   <= 1'b0;
        end else begin
            sclk_sh <= (sclk_sh << 1) | SYNC_STAGES'(sclk);
            csn_sh  <= (csn_sh << 1) | SYNC_STAGES'(csn);
            mosi_sh <= (mosi_sh << 1) | SYNC_STAGES'(mosi);
            fill    <= (fill << 1) | SYNC_STAGES'(1'b1);
            sclk_d  <= sclk_s;
            csn_d   <= csn_s;
            armed   <= armed | (fill[SYNC_STAGES-1] & csn_s);
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign csn_fall  = armed & csn_d & ~csn_s;
    assign csn_rise  = csn_s & ~csn_d;
endmodule

// File: rtl/adxl362_spi_responder.sv
// adxl362_spi_responder: SPI mode-0 slave emulating the ADXL362 register interface.
// Ports: CLK100MHZ, rst_n (sync, active-low); ACL_SCLK/ACL_CSN/ACL_MOSI/ACL_MISO SPI pins;
//        x_in/y_in/z_in 12-bit samples with sample_valid strobe; busy transaction active;
//        power_ctl contents of register 0x2D.
// Build option: ADXL362_RESP_SNAPSHOT_EN freezes x/y/z at CSN fall for the whole transaction.
module adxl362_spi_responder
    import adxl362_spi_responder_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] PART_ID     = 8'hF2
) (
    input  logic        CLK100MHZ,
    input  logic        rst_n,
    input  logic        ACL_SCLK,
    input  logic        ACL_CSN,
    input  logic        ACL_MOSI,
    output logic        ACL_MISO,
    input  logic [11:0] x_in,
    input  logic [11:0] y_in,
    input  logic [11:0] z_in,
    input  logic        sample_valid,
    output logic        busy,
    output logic [7:0]  power_ctl
);
    state_t      state, state_n;
    logic        sclk_rise, sclk_fall, csn_fall, csn_rise, mosi_bit;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx;
    logic [7:0]  rx_byte, addr, rd_addr, rd_data, tx;
    logic [3:0]  rd_idx, wr_idx;
    logic        is_read, byte_done;
    logic [7:0]  wfile [0:14];
    logic [11:0] x_r, y_r, z_r, x_src, y_src, z_src;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (CLK100MHZ),
        .rst_n     (rst_n),
        .sclk      (ACL_SCLK),
        .csn       (ACL_CSN),
        .mosi      (ACL_MOSI),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csn_fall  (csn_fall),
        .csn_rise  (csn_rise),
        .mosi_bit  (mosi_bit)
    );

`ifdef ADXL362_RESP_SNAPSHOT_EN
    logic [11:0] x_snap, y_snap, z_snap;
    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) {x_snap, y_snap, z_snap} <= '0;
        else if (csn_fall) {x_snap, y_snap, z_snap} <= {x_r, y_r, z_r};
    end
    assign {x_src, y_src, z_src} = {x_snap, y_snap, z_snap};
`else
    assign {x_src, y_src, z_src} = {x_r, y_r, z_r};
`endif

    assign rx_byte   = {rx, mosi_bit};
    assign byte_done = sclk_rise && bit_cnt == 3'd7 && (state == CMD || state == ADDR || state == DATA);
    assign busy      = state != IDLE;
    assign power_ctl = wfile[4'(A_POWER_CTL - A_FILE_FIRST)];
    // The byte to serve next: the freshly received address, or the auto-incremented one.
    assign rd_addr   = (state == ADDR) ? rx_byte : addr + 8'd1;
    assign rd_idx    = 4'(rd_addr - A_FILE_FIRST);
    assign wr_idx    = 4'(addr - A_FILE_FIRST);

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            A_DEVID_AD:  rd_data = DEVID_AD_VAL;
            A_DEVID_MST: rd_data = DEVID_MST_VAL;
            A_PARTID:    rd_data = PART_ID;
            A_REVID:     rd_data = REVID_VAL;
            A_XDATA:     rd_data = x_src[11:4];
            A_YDATA:     rd_data = y_src[11:4];
            A_ZDATA:     rd_data = z_src[11:4];
            A_STATUS:    rd_data = STATUS_VAL;
            A_XDATA_L:   rd_data = x_src[7:0];
            A_XDATA_H:   rd_data = high_byte(x_src);
            A_YDATA_L:   rd_data = y_src[7:0];
            A_YDATA_H:   rd_data = high_byte(y_src);
            A_ZDATA_L:   rd_data = z_src[7:0];
            A_ZDATA_H:   rd_data = high_byte(z_src);
            default:     rd_data = (rd_addr >= A_FILE_FIRST && rd_addr <= A_FILE_LAST) ? wfile[rd_idx] : 8'h00;
        endcase
    end

    always_comb begin
        state_n = state;
        if (csn_rise) state_n = IDLE;
        else if (state == IDLE) state_n = csn_fall ? CMD : IDLE;
        else if (byte_done && state == CMD) state_n = (rx_byte == CMD_READ || rx_byte == CMD_WRITE) ? ADDR : SKIP;
        else if (byte_done && state == ADDR) state_n = DATA;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            rx       <= 7'd0;
            addr     <= 8'h00;
            tx       <= 8'h00;
            is_read  <= 1'b0;
            ACL_MISO <= 1'b0;
            x_r      <= 12'h000;
            y_r      <= 12'h000;
            z_r      <= 12'h000;
            for (int i = 0; i < 15; i++) wfile[i] <= 8'h00;
        end else begin
            state <= state_n;
            if (sample_valid) {x_r, y_r, z_r} <= {x_in, y_in, z_in};
            if (csn_rise || state == IDLE) begin
                bit_cnt  <= 3'd0;
                ACL_MISO <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx      <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done && state == CMD) is_read <= rx_byte == CMD_READ;
                // The next read byte is latched whole here, so a sample update
                // landing mid-byte cannot tear the bits being shifted out.
                if (byte_done && (state == ADDR || state == DATA)) begin
                    addr <= rd_addr;
                    if (is_read) tx <= rd_data;
                end
                if (byte_done && state == DATA && !is_read) begin
                    if (addr >= A_FILE_FIRST && addr <= A_FILE_LAST) wfile[wr_idx] <= rx_byte;
                    else if (addr == A_SOFT_RESET && rx_byte == SOFT_RESET_KEY)
                        for (int i = 0; i < 15; i++) wfile[i] <= 8'h00;
                end
                if (state != DATA || !is_read) ACL_MISO <= 1'b0;
                else if (sclk_fall) begin
                    ACL_MISO <= tx[7];
                    tx       <= {tx[6:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_adxl362_spi_responder.sv
// tb_adxl362_spi_responder: randomized SPI master with a register-map model and a MISO scoreboard.
module tb_adxl362_spi_responder;
    localparam int HALF = 6;

    typedef struct {
        logic [7:0] v;
        bit         chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        csn = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [11:0] x_in = 12'h000, y_in = 12'h000, z_in = 12'h000;
    logic        sample_valid = 1'b0;
    logic        busy;
    logic [7:0]  pctl;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mfile [0:255];
    logic [11:0] mx = 12'h000, my = 12'h000, mz = 12'h000;

    always #5 clk = ~clk;

    adxl362_spi_responder #(.SYNC_STAGES(2), .PART_ID(8'hF2)) dut (
        .CLK100MHZ    (clk),
        .rst_n        (rst_n),
        .ACL_SCLK     (sclk),
        .ACL_CSN      (csn),
        .ACL_MOSI     (mosi),
        .ACL_MISO     (miso),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .sample_valid (sample_valid),
        .busy         (busy),
        .power_ctl    (pctl)
    );

    // Register map from the datasheet rules, using signed integer arithmetic.
    function automatic logic [7:0] mread(input logic [7:0] a, input logic [11:0] sx, input logic [11:0] sy, input logic [11:0] sz);
        int s [3];
        int ai;
        s[0] = 32'($signed(sx));
        s[1] = 32'($signed(sy));
        s[2] = 32'($signed(sz));
        ai = int'(a);
        if (ai >= 8 && ai <= 10) return 8'((s[ai-8] >>> 4) & 255);
        if (ai >= 14 && ai <= 19) return 8'(((ai % 2 == 0) ? s[(ai-14)/2] : (s[(ai-14)/2] >>> 8)) & 255);
        if (ai >= 32 && ai <= 46) return mfile[a];
        case (ai)
            0:       return 8'hAD;
            1:       return 8'h1D;
            2:       return 8'hF2;
            3:       return 8'h01;
            11:      return 8'h41;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] v, input bit c);
        exp_t e;
        e.v = v;
        e.chk = c;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] v, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = v[i];
            tick(HALF);
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic begin_x();
        csn = 1'b0;
        tick(HALF);
    endtask

    task automatic end_x();
        tick(HALF);
        csn = 1'b1;
        tick(4 * HALF);
        chk("miso_csn_high", 32'(miso), 32'd0);
    endtask

    task automatic strobe(input logic [11:0] nx, input logic [11:0] ny, input logic [11:0] nz);
        x_in = nx;
        y_in = ny;
        z_in = nz;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        mx = nx;
        my = ny;
        mz = nz;
    endtask

    task automatic do_read(input logic [7:0] a, input int n);
        begin_x();
        push(8'h00, 1'b0);
        send(8'h0B, 8);
        push(8'h00, 1'b0);
        send(a, 8);
        for (int k = 0; k < n; k++) begin
            push(mread(a + 8'(k), mx, my, mz), 1'b1);
            send(8'($urandom), 8);
        end
        end_x();
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input int n);
        logic [7:0] d [3];
        logic [7:0] ad;
        d[0] = d0;
        d[1] = d1;
        d[2] = d2;
        begin_x();
        push(8'h00, 1'b0);
        send(8'h0A, 8);
        push(8'h00, 1'b0);
        send(a, 8);
        for (int k = 0; k < n; k++) begin
            push(8'h00, 1'b0);
            send(d[k], 8);
            ad = a + 8'(k);
            if (ad >= 8'h20 && ad <= 8'h2E) mfile[ad] = d[k];
            else if (ad == 8'h1F && d[k] == 8'h52)
                for (int i = 32; i <= 46; i++) mfile[i] = 8'h00;
        end
        end_x();
        chk("power_ctl", 32'(pctl), 32'(mfile[8'h2D]));
    endtask

    // Monitor: assembles MISO bytes at each SCLK rise and scores them against the queue.
    initial begin
        logic [7:0] sh;
        int nb;
        exp_t e;
        sh = 8'h00;
        nb = 0;
        forever begin
            @(posedge sclk or posedge csn);
            if (csn) nb = 0;
            else begin
                sh = {sh[6:0], miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL miso_unexpected_byte: got %02h expected none", sh);
                    end else begin
                        e = q.pop_front();
                        if (e.chk) begin
                            checks++;
                            if (sh !== e.v) begin
                                errors++;
                                $display("FAIL miso_byte: got %02h expected %02h", sh, e.v);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        logic [11:0] ox, oy, oz;
        foreach (mfile[i]) mfile[i] = 8'h00;
        tick(5);
        rst_n = 1'b1;
        tick(5);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_power_ctl", 32'(pctl), 32'd0);
        chk("reset_miso", 32'(miso), 32'd0);

        do_read(8'h00, 3);
        strobe(12'hF85, 12'h123, 12'h876);
        do_read(8'h0E, 2);
        do_read(8'h08, 6);

        do_write(8'h2D, 8'h02, 8'h00, 8'h00, 1);
        do_write(8'h1F, 8'h52, 8'h00, 8'h00, 1);

        do_write(8'h2D, 8'h03, 8'h00, 8'h00, 1);
        begin_x();
        chk("busy_active", 32'(busy), 32'd1);
        push(8'h00, 1'b0);
        send(8'h0A, 8);
        push(8'h00, 1'b0);
        send(8'h2D, 8);
        send(8'h55, 5);
        tick(HALF);
        csn = 1'b1;
        tick(4);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_miso", 32'(miso), 32'd0);
        chk("abort_power_ctl", 32'(pctl), 32'h03);
        tick(4 * HALF);

        begin_x();
        push(8'h00, 1'b1);
        send(8'h0D, 8);
        push(8'h00, 1'b1);
        send(8'h00, 8);
        push(8'h00, 1'b1);
        send(8'($urandom), 8);
        push(8'h00, 1'b1);
        send(8'($urandom), 8);
        end_x();
        do_read(8'h00, 1);

        do_read(8'hFE, 3);

        strobe(12'h7A5, 12'h80C, 12'h3F0);
        begin_x();
        push(8'h00, 1'b0);
        send(8'h0B, 8);
        push(8'h00, 1'b0);
        send(8'h0E, 8);
        push(mread(8'h0E, mx, my, mz), 1'b1);
        send(8'h00, 8);
        ox = mx;
        oy = my;
        oz = mz;
        strobe(12'h15A, 12'hE61, 12'h9C3);
        push(mread(8'h0F, ox, oy, oz), 1'b1);
        send(8'h00, 8);
        for (int k = 2; k < 6; k++) begin
`ifdef ADXL362_RESP_SNAPSHOT_EN
            push(mread(8'h0E + 8'(k), ox, oy, oz), 1'b1);
`else
            push(mread(8'h0E + 8'(k), mx, my, mz), 1'b1);
`endif
            send(8'h00, 8);
        end
        end_x();

        do_write(8'h2D, 8'h07, 8'h00, 8'h00, 1);
        begin_x();
        push(8'h00, 1'b0);
        send(8'h0B, 8);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int i = 32; i <= 46; i++) mfile[i] = 8'h00;
        mx = 12'h000;
        my = 12'h000;
        mz = 12'h000;
        tick(1);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_power_ctl", 32'(pctl), 32'd0);
        push(8'h00, 1'b1);
        send(8'h00, 8);
        push(8'h00, 1'b1);
        send(8'h0B, 8);
        chk("midreset_still_idle", 32'(busy), 32'd0);
        end_x();
        do_read(8'h00, 2);
        do_read(8'h0E, 2);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: strobe(12'($urandom), 12'($urandom), 12'($urandom));
                1: begin
                    a = ($urandom_range(0, 1) == 1) ? 8'(32 + $urandom_range(0, 14)) : 8'($urandom);
                    if ($urandom_range(0, 7) == 0) do_write(8'h1F, 8'h52, 8'h00, 8'h00, 1);
                    else do_write(a, 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(1, 3)));
                end
                default: begin
                    a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 47)) : 8'($urandom);
                    do_read(a, int'($urandom_range(1, 4)));
                end
            endcase
        end

        tick(20);
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
